mx_block_pe_ctrl: RTL
=====================

# mx_block_pe_ctrl

Sequencer for one MX Block PE wrapper. It latches a per-job mode configuration and joins the A and B operand streams into paired beats for the PE. It counts K beats of accumulation, waits out the PE pipeline, then drives the requantize/send phase and hands the quantized block to a downstream valid/ready consumer. It sits between the streamer/CSR front end and the PE wrapper's control pins.

## Interface
Parameters:
- K_WIDTH, 16, width of the K-beat count (max job = 2^K_WIDTH-1 beats)
- PIPE_LAT, 3, cycles from last accepted beat until the PE accumulator is final
- QUAN_LAT, 1, cycles from send_output rising until quantized Out/shared_exp_out are valid

Ports:
- clk_i  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  job request, sampled only in IDLE
- cfg_prec_mode_i, cfg_fp_mode_i, cfg_prec_mode_quan_i, cfg_fp_mode_quan_i  in  2 each  job modes
- cfg_k_i  in  K_WIDTH  number of paired beats to accumulate
- abort_i  in  1  synchronous job kill
- a_valid_i, b_valid_i  in  1  upstream operand valids
- a_ready_o, b_ready_o  out  1  upstream operand readies
- pe_a_valid_o, pe_b_valid_o  out  1  to PE A_valid/B_valid
- pe_prec_mode_o, pe_fp_mode_o, pe_prec_mode_quan_o, pe_fp_mode_quan_o  out  2 each  latched modes to PE
- pe_send_output_o  out  1  to PE send_output
- out_valid_o  out  1  quantized block valid downstream
- out_ready_i  in  1  downstream ready
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on output handoff
- cfg_err_o  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, ACCUM, DRAIN, QUAN, SEND.
- IDLE: start_i=1 with a legal config -> latch all cfg_* into mode registers, load k_cnt=cfg_k_i, go to ACCUM. Illegal config: cfg_k_i==0 or cfg_prec_mode_i==2'b10. In that case stay in IDLE, pulse cfg_err_o, and leave mode registers unchanged.
- ACCUM: fire = a_valid_i & b_valid_i. a_ready_o = b_valid_i; b_ready_o = a_valid_i. Operands are only ever consumed as a pair. pe_a_valid_o = pe_b_valid_o = fire. Each fire decrements k_cnt. On the fire that brings k_cnt to 0, go to DRAIN with d_cnt=PIPE_LAT-1. Readies are 0 in every other state.
- DRAIN: d_cnt counts down. At 0, go to QUAN, assert pe_send_output_o, and load q_cnt=QUAN_LAT-1.
- QUAN: pe_send_output_o=1. q_cnt counts down. At 0, go to SEND.
- SEND: pe_send_output_o=1 and out_valid_o=1, both held until out_ready_i. On the out_valid_o & out_ready_i cycle, pulse done_o and return to IDLE. pe_send_output_o drops the next cycle.
- Mode outputs always reflect the mode registers, which are stable for the whole job.
- abort_i in any non-IDLE state: return to IDLE next cycle, deassert all valids and send_output, no done_o. abort_i has priority over every other transition.
- start_i outside IDLE is ignored and no error is raised.

## Timing
- Reset values: state IDLE, all counters 0, mode registers 2'b00, every output 0.
- Start accepted at cycle t -> busy_o=1 and readies may be high at t+1.
- Minimum job latency, from the start cycle to out_valid_o with continuous operands: 1 + K + PIPE_LAT + QUAN_LAT cycles.
- Backpressure: upstream bubbles simply stall ACCUM. The PE never sees a lone A or B valid.
- k_cnt reaching 0 and abort_i in the same cycle: abort wins and the beat is still forwarded to the PE that cycle.
- out_ready_i held 1 before SEND: the handoff occurs on the first SEND cycle.
- cfg_k_i = 2^K_WIDTH-1: no wrap; the counter only decrements.
- Reset asserted mid-job: immediate return to reset values regardless of clock.

## Test plan
- Legal job, FP8 E4M3 (prec=01, fp=10), K=4, continuous valids, PIPE_LAT=3, QUAN_LAT=1, out_ready_i=1 -> 4 PE fires on cycles t+1..t+4, send_output from t+8, out_valid_o and done_o at t+9.
- K=3 with a_valid_i toggling every other cycle and b_valid_i=1 -> exactly 3 fires, each coinciding with a_valid_i=1; b_ready_o mirrors a_valid_i.
- start_i with cfg_k_i=0, then with prec=10 -> cfg_err_o pulses each time, busy_o stays 0, mode outputs unchanged.
- SEND with out_ready_i low for 5 cycles -> out_valid_o and pe_send_output_o held 5 cycles, done_o on the 6th cycle.
- abort_i during ACCUM after 2 of 8 beats -> IDLE next cycle, no done_o, readies 0; a new job with K=1 then completes normally.
- rstn pulsed low mid-DRAIN -> all outputs 0 asynchronously, state IDLE after release.

Source files
------------

// File: rtl/mx_block_pe_ctrl_if.sv
// Handshake bundle for mx_block_pe_ctrl: paired A/B operand streams in,
// quantized-block valid/ready out. The controller takes the slave view.
interface mx_block_pe_ctrl_if;
    logic a_valid;
    logic a_ready;
    logic b_valid;
    logic b_ready;
    logic out_valid;
    logic out_ready;

    // Front end / consumer side: drives operand valids and output ready
    modport master (
        output a_valid,
        output b_valid,
        output out_ready,
        input  a_ready,
        input  b_ready,
        input  out_valid
    );

    // Controller side
    modport slave (
        input  a_valid,
        input  b_valid,
        input  out_ready,
        output a_ready,
        output b_ready,
        output out_valid
    );
endinterface

// File: rtl/mx_block_pe_ctrl.sv
// Job sequencer for one MX Block PE wrapper: latches per-job modes, pairs
// A/B operand beats, counts K accumulations, waits out the PE pipeline,
// then runs requantize and hands the block to a valid/ready consumer.
module mx_block_pe_ctrl #(
    parameter int K_WIDTH  = 16,
    parameter int PIPE_LAT = 3,
    parameter int QUAN_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [1:0]         cfg_prec_mode_i,
    input  logic [1:0]         cfg_fp_mode_i,
    input  logic [1:0]         cfg_prec_mode_quan_i,
    input  logic [1:0]         cfg_fp_mode_quan_i,
    input  logic [K_WIDTH-1:0] cfg_k_i,
    input  logic               abort_i,
    mx_block_pe_ctrl_if.slave  strm,
    output logic               pe_a_valid_o,
    output logic               pe_b_valid_o,
    output logic [1:0]         pe_prec_mode_o,
    output logic [1:0]         pe_fp_mode_o,
    output logic [1:0]         pe_prec_mode_quan_o,
    output logic [1:0]         pe_fp_mode_quan_o,
    output logic               pe_send_output_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int QW = (QUAN_LAT > 1) ? $clog2(QUAN_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        QUAN  = 3'd3,
        SEND  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
    logic [DW-1:0]      d_cnt_q, d_cnt_d;
    logic [QW-1:0]      q_cnt_q, q_cnt_d;
    logic [1:0]         prec_q, prec_d;
    logic [1:0]         fp_q, fp_d;
    logic [1:0]         prec_quan_q, prec_quan_d;
    logic [1:0]         fp_quan_q, fp_quan_d;

    logic cfg_legal;
    logic fire;
    logic a_ready, b_ready, out_valid;

    assign cfg_legal = (cfg_k_i != '0) && (cfg_prec_mode_i != 2'b10);
    assign fire      = (state_q == ACCUM) && strm.a_valid && strm.b_valid;

    // State, counters and mode registers
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            d_cnt_q     <= '0;
            q_cnt_q     <= '0;
            prec_q      <= '0;
            fp_q        <= '0;
            prec_quan_q <= '0;
            fp_quan_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            d_cnt_q     <= d_cnt_d;
            q_cnt_q     <= q_cnt_d;
            prec_q      <= prec_d;
            fp_q        <= fp_d;
            prec_quan_q <= prec_quan_d;
            fp_quan_q   <= fp_quan_d;
        end
    end

    // Next-state and counter update; abort overrides every transition
    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        d_cnt_d     = d_cnt_q;
        q_cnt_d     = q_cnt_q;
        prec_d      = prec_q;
        fp_d        = fp_q;
        prec_quan_d = prec_quan_q;
        fp_quan_d   = fp_quan_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && cfg_legal) begin
                    prec_d      = cfg_prec_mode_i;
                    fp_d        = cfg_fp_mode_i;
                    prec_quan_d = cfg_prec_mode_quan_i;
                    fp_quan_d   = cfg_fp_mode_quan_i;
                    k_cnt_d     = cfg_k_i;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (fire) begin
                    k_cnt_d = k_cnt_q - K_WIDTH'(1);
                    if (k_cnt_q == K_WIDTH'(1)) begin
                        d_cnt_d = DW'(PIPE_LAT - 1);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (d_cnt_q == '0) begin
                    q_cnt_d = QW'(QUAN_LAT - 1);
                    state_d = QUAN;
                end else begin
                    d_cnt_d = d_cnt_q - DW'(1);
                end
            end
            QUAN: begin
                if (q_cnt_q == '0) begin
                    state_d = SEND;
                end else begin
                    q_cnt_d = q_cnt_q - QW'(1);
                end
            end
            SEND: begin
                if (strm.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Outputs decoded from state; the beat on an aborting cycle is still forwarded
    always_comb begin
        a_ready          = 1'b0;
        b_ready          = 1'b0;
        out_valid        = 1'b0;
        pe_a_valid_o     = 1'b0;
        pe_b_valid_o     = 1'b0;
        pe_send_output_o = 1'b0;
        done_o           = 1'b0;
        cfg_err_o        = 1'b0;
        busy_o           = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                cfg_err_o = start_i && !cfg_legal;
            end
            ACCUM: begin
                a_ready      = strm.b_valid;
                b_ready      = strm.a_valid;
                pe_a_valid_o = fire;
                pe_b_valid_o = fire;
            end
            DRAIN: begin
            end
            QUAN: begin
                pe_send_output_o = 1'b1;
            end
            SEND: begin
                pe_send_output_o = 1'b1;
                out_valid        = 1'b1;
                done_o           = strm.out_ready && !abort_i;
            end
            default: begin
            end
        endcase
    end

    assign strm.a_ready   = a_ready;
    assign strm.b_ready   = b_ready;
    assign strm.out_valid = out_valid;

    assign pe_prec_mode_o      = prec_q;
    assign pe_fp_mode_o        = fp_q;
    assign pe_prec_mode_quan_o = prec_quan_q;
    assign pe_fp_mode_quan_o   = fp_quan_q;

endmodule
